// File: rtl/transform_hcnt_v2.sv
// Output-row / kernel-row walker for a height transform: steps (oh, kh) on each
// hcnt flag and derives the signed input row index and its padding status.
//
// state | meaning
// IDLE  | waiting for a start edge
// LOAD  | latch configuration, clear counters
// RUN   | advance kh/oh on each I_hcnt_flag
// DONE  | one-cycle terminal state, raises O_done next cycle
module transform_hcnt_v2 #(
    parameter int C_W_WIDTH = 10,
    parameter int C_KWIDTH  = 4,
    parameter int C_SWIDTH  = 2,
    parameter int C_PWIDTH  = 2,
    parameter int C_DWIDTH  = 2
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_ap_start,
    input  logic                 I_hcnt_flag,
    input  logic [C_W_WIDTH-1:0] I_oheight,
    input  logic [C_W_WIDTH-1:0] I_iheight,
    input  logic [C_KWIDTH-1:0]  I_kernel_h,
    input  logic [C_SWIDTH-1:0]  I_stride_h,
    input  logic [C_PWIDTH-1:0]  I_pad_h,
    input  logic [C_DWIDTH-1:0]  I_dilation_h,
    output logic [C_W_WIDTH-1:0] O_oh,
    output logic [C_W_WIDTH-1:0] O_h,
    output logic [C_KWIDTH-1:0]  O_kh,
    output logic [C_W_WIDTH:0]   O_hindex,
    output logic                 O_pad_row,
    output logic                 O_compute_en,
    output logic                 O_compute_en_real,
    output logic                 O_last_line,
    output logic                 O_busy,
    output logic                 O_done
);
    localparam int HW = C_W_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic                 start_prev, start_edge;
    logic [C_W_WIDTH-1:0] oheight_q, iheight_q;
    logic [C_KWIDTH-1:0]  kernel_h_q;
    logic [C_SWIDTH-1:0]  stride_q;
    logic [C_PWIDTH-1:0]  pad_q;
    logic [C_DWIDTH-1:0]  dil_q;
    logic [HW-1:0]        acc, acc_nxt;
    logic [C_W_WIDTH-1:0] oh_nxt, h_nxt;
    logic [C_KWIDTH-1:0]  kh_nxt;
    logic                 last_nxt;
    logic [HW-1:0]        hidx_nxt;
    logic                 ce_d1;

    assign start_edge = I_ap_start & ~start_prev;
    assign O_busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        oh_nxt    = O_oh;
        h_nxt     = O_h;
        kh_nxt    = O_kh;
        acc_nxt   = acc;
        last_nxt  = O_last_line;
        case (state)
            IDLE: if (start_edge) state_nxt = LOAD;
            LOAD: begin
                oh_nxt   = '0;
                h_nxt    = '0;
                kh_nxt   = '0;
                acc_nxt  = '0;
                last_nxt = 1'b0;
                // Decide on the values being latched this cycle.
                state_nxt = (I_oheight == '0 || I_kernel_h == '0) ? DONE : RUN;
            end
            RUN: begin
                if (start_edge) begin
                    state_nxt = LOAD;
                end else if (I_hcnt_flag) begin
                    if (O_kh == kernel_h_q - C_KWIDTH'(1)) begin
                        if (O_oh == oheight_q - C_W_WIDTH'(1)) begin
                            state_nxt = DONE;
                        end else begin
                            kh_nxt  = '0;
                            acc_nxt = '0;
                            oh_nxt  = O_oh + C_W_WIDTH'(1);
                            h_nxt   = O_h + C_W_WIDTH'(stride_q);
                        end
                    end else begin
                        kh_nxt  = O_kh + C_KWIDTH'(1);
                        acc_nxt = acc + HW'(dil_q);
                    end
                end
                if (oh_nxt == oheight_q - C_W_WIDTH'(1)) last_nxt = 1'b1;
            end
            DONE: state_nxt = start_edge ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Two's complement wrap at HW bits gives the signed row index directly.
    assign hidx_nxt = {1'b0, O_h} + acc - HW'(pad_q);

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state             <= IDLE;
            start_prev        <= 1'b0;
            oheight_q         <= '0;
            iheight_q         <= '0;
            kernel_h_q        <= '0;
            stride_q          <= '0;
            pad_q             <= '0;
            dil_q             <= '0;
            acc               <= '0;
            O_oh              <= '0;
            O_h               <= '0;
            O_kh              <= '0;
            O_last_line       <= 1'b0;
            O_hindex          <= '0;
            O_pad_row         <= 1'b0;
            O_compute_en      <= 1'b0;
            ce_d1             <= 1'b0;
            O_compute_en_real <= 1'b0;
            O_done            <= 1'b0;
        end else begin
            state       <= state_nxt;
            start_prev  <= I_ap_start;
            acc         <= acc_nxt;
            O_oh        <= oh_nxt;
            O_h         <= h_nxt;
            O_kh        <= kh_nxt;
            O_last_line <= last_nxt;
            if (state == LOAD) begin
                oheight_q  <= I_oheight;
                iheight_q  <= I_iheight;
                kernel_h_q <= I_kernel_h;
                stride_q   <= I_stride_h;
                pad_q      <= I_pad_h;
                dil_q      <= I_dilation_h;
            end
            if (state != IDLE) begin
                O_hindex  <= hidx_nxt;
                O_pad_row <= hidx_nxt[HW-1] || (hidx_nxt >= {1'b0, iheight_q});
            end
            O_compute_en      <= (state == RUN);
            ce_d1             <= O_compute_en;
            O_compute_en_real <= ce_d1;
            O_done            <= (state == DONE) && !start_edge;
        end
    end
endmodule

// File: tb/tb_transform_hcnt_v2.sv
// Directed bench for transform_hcnt_v2: hand-computed row-index sequences,
// empty pass, restart, mid-pass reset and compute-enable delay.
module tb_transform_hcnt_v2;
    logic        I_clk = 1'b0;
    logic        I_rst, I_ap_start, I_hcnt_flag;
    logic [9:0]  I_oheight, I_iheight;
    logic [3:0]  I_kernel_h;
    logic [1:0]  I_stride_h, I_pad_h, I_dilation_h;
    logic [9:0]  O_oh, O_h;
    logic [3:0]  O_kh;
    logic [10:0] O_hindex;
    logic        O_pad_row, O_compute_en, O_compute_en_real, O_last_line, O_busy, O_done;

    int checks = 0;
    int failures = 0;

    transform_hcnt_v2 dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_ap_start(I_ap_start), .I_hcnt_flag(I_hcnt_flag),
        .I_oheight(I_oheight), .I_iheight(I_iheight), .I_kernel_h(I_kernel_h),
        .I_stride_h(I_stride_h), .I_pad_h(I_pad_h), .I_dilation_h(I_dilation_h),
        .O_oh(O_oh), .O_h(O_h), .O_kh(O_kh), .O_hindex(O_hindex), .O_pad_row(O_pad_row),
        .O_compute_en(O_compute_en), .O_compute_en_real(O_compute_en_real),
        .O_last_line(O_last_line), .O_busy(O_busy), .O_done(O_done)
    );

    always #5 I_clk = ~I_clk;

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int k, input int s, input int p, input int d, input int oh, input int ih);
        I_kernel_h   = 4'(k);
        I_stride_h   = 2'(s);
        I_pad_h      = 2'(p);
        I_dilation_h = 2'(d);
        I_oheight    = 10'(oh);
        I_iheight    = 10'(ih);
    endtask

    // Start edge, then LOAD and first RUN cycle so the first hindex is valid.
    task automatic start_pass();
        I_ap_start = 1'b1;
        tick();
        I_ap_start = 1'b0;
        tick();
        tick();
    endtask

    task automatic flag();
        I_hcnt_flag = 1'b1;
        tick();
        I_hcnt_flag = 1'b0;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_oh"}, int'(O_oh), 0);
        chk({tag, "_h"}, int'(O_h), 0);
        chk({tag, "_kh"}, int'(O_kh), 0);
        chk({tag, "_hindex"}, int'(O_hindex), 0);
        chk({tag, "_pad_row"}, int'(O_pad_row), 0);
        chk({tag, "_ce"}, int'(O_compute_en), 0);
        chk({tag, "_ce_real"}, int'(O_compute_en_real), 0);
        chk({tag, "_last"}, int'(O_last_line), 0);
        chk({tag, "_busy"}, int'(O_busy), 0);
        chk({tag, "_done"}, int'(O_done), 0);
    endtask

    initial begin
        int exp3[12] = '{-1, 0, 1, 0, 1, 2, 1, 2, 3, 2, 3, 4};
        int exp5[10] = '{-2, 0, 2, 4, 6, 0, 2, 4, 6, 8};
        int ce_exp[8] = '{0, 0, 1, 1, 0, 0, 0, 0};
        int re_exp[8] = '{0, 0, 0, 0, 1, 1, 0, 0};

        I_rst = 1'b1; I_ap_start = 1'b0; I_hcnt_flag = 1'b0;
        cfg(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_all_zero("reset");
        I_rst = 1'b0;
        tick();

        // 3x3: K=3 S=1 P=1 D=1 OH=IH=4
        cfg(3, 1, 1, 1, 4, 4);
        start_pass();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("k3_hindex_%0d", i), int'($signed(O_hindex)), exp3[i]);
            chk($sformatf("k3_pad_%0d", i), int'(O_pad_row), (exp3[i] < 0 || exp3[i] >= 4) ? 1 : 0);
            chk($sformatf("k3_last_%0d", i), int'(O_last_line), (i >= 9) ? 1 : 0);
            chk($sformatf("k3_ce_%0d", i), int'(O_compute_en), 1);
            flag();
        end
        chk("k3_done_pulse", int'(O_done), 1);
        chk("k3_busy_after", int'(O_busy), 0);
        chk("k3_oh_held", int'(O_oh), 3);
        chk("k3_kh_held", int'(O_kh), 2);
        tick();
        chk("k3_done_once", int'(O_done), 0);

        // K=5 S=2 P=2 D=2 OH=2 IH=6
        cfg(5, 2, 2, 2, 2, 6);
        start_pass();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("k5_hindex_%0d", i), int'($signed(O_hindex)), exp5[i]);
            chk($sformatf("k5_pad_%0d", i), int'(O_pad_row), (exp5[i] < 0 || exp5[i] >= 6) ? 1 : 0);
            chk($sformatf("k5_oh_%0d", i), int'(O_oh), (i >= 5) ? 1 : 0);
            chk($sformatf("k5_h_%0d", i), int'(O_h), (i >= 5) ? 2 : 0);
            chk($sformatf("k5_last_%0d", i), int'(O_last_line), (i >= 5) ? 1 : 0);
            flag();
        end
        chk("k5_done_pulse", int'(O_done), 1);
        tick();

        // Empty pass: OH=0
        cfg(3, 1, 1, 1, 0, 4);
        I_ap_start = 1'b1;
        tick();
        I_ap_start = 1'b0;
        chk("oh0_busy_load", int'(O_busy), 1);
        chk("oh0_ce_load", int'(O_compute_en), 0);
        tick();
        chk("oh0_ce_done", int'(O_compute_en), 0);
        chk("oh0_done_early", int'(O_done), 0);
        tick();
        chk("oh0_done_pulse", int'(O_done), 1);
        chk("oh0_ce_after", int'(O_compute_en), 0);
        tick();
        chk("oh0_done_once", int'(O_done), 0);

        // Restart after 5 flags
        cfg(3, 1, 1, 1, 4, 4);
        start_pass();
        for (int i = 0; i < 5; i++) flag();
        chk("rs_oh_before", int'(O_oh), 1);
        chk("rs_kh_before", int'(O_kh), 2);
        I_ap_start = 1'b1;
        tick();
        I_ap_start = 1'b0;
        chk("rs_no_done_a", int'(O_done), 0);
        tick();
        chk("rs_oh_cleared", int'(O_oh), 0);
        chk("rs_kh_cleared", int'(O_kh), 0);
        chk("rs_h_cleared", int'(O_h), 0);
        chk("rs_no_done_b", int'(O_done), 0);
        tick();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("rs_hindex_%0d", i), int'($signed(O_hindex)), exp3[i]);
            chk($sformatf("rs_done_%0d", i), int'(O_done), 0);
            flag();
        end
        chk("rs_done_pulse", int'(O_done), 1);
        tick();

        // Reset mid-RUN, with start and flag asserted alongside reset
        start_pass();
        for (int i = 0; i < 3; i++) flag();
        I_rst = 1'b1; I_ap_start = 1'b1; I_hcnt_flag = 1'b1;
        tick();
        chk_all_zero("midrst");
        I_rst = 1'b0; I_ap_start = 1'b0; I_hcnt_flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            flag();
            chk($sformatf("idle_kh_%0d", i), int'(O_kh), 0);
            chk($sformatf("idle_busy_%0d", i), int'(O_busy), 0);
            chk($sformatf("idle_done_%0d", i), int'(O_done), 0);
        end

        // compute_en / compute_en_real, single-flag pass K=1 OH=1
        cfg(1, 1, 0, 1, 1, 4);
        I_ap_start = 1'b1;
        tick();
        I_ap_start = 1'b0;
        for (int t = 0; t < 8; t++) begin
            chk($sformatf("ce_%0d", t), int'(O_compute_en), ce_exp[t]);
            chk($sformatf("ce_real_%0d", t), int'(O_compute_en_real), re_exp[t]);
            chk($sformatf("ce_done_%0d", t), int'(O_done), (t == 4) ? 1 : 0);
            I_hcnt_flag = (t == 2);
            tick();
        end
        I_hcnt_flag = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
